fifo_wr_arbiter: RTL and testbench

//  - Shares the write port of one FIFO (wr_en/data_in/full) between NUM_REQ requesters in the write-clock domain.
//  - Uses round-robin arbitration with a valid/ready handshake per requester and zero-latency pass-through to the FIFO.
//  - Sits between producer blocks and the FIFO write side. It never writes while full is asserted.

---
 rtl/fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional feature: FIFO_ARB_BURST_EN enables grant locking for bursts.
package fifo_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`define FIFO_ARB_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

// File: rtl/rr_pick.sv
// Round-robin pick: first valid requester at or after ptr_i.
// Double-width rotate followed by a priority encoder.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW:0] NR = (IW+1)'(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;
  logic          found;

  // rotate so ptr_i lands at bit 0, then take the lowest set bit
  always_comb begin
    rot   = N'({req_i, req_i} >> ptr_i);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = i[IW-1:0];
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NR) sum = sum - NR;
    any_o = found;
    idx_o = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, zero-latency.
// Define FIFO_ARB_BURST_EN to lock a grant for up to MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BURST = 4,
  localparam int IW        = idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data,
  output logic                     grant_valid,
  output logic [IW-1:0]            grant_id
);

  if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: NUM_REQ must be >=2, MAX_BURST >=1");
  end

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    return (g == IW'(NUM_REQ-1)) ? '0 : g + 1'b1;
  endfunction

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          gv;
  logic [IW-1:0] gid;
  logic          accept;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST+1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // locked owner overrides the round-robin pick
  always_comb begin
    gid = pick_idx;
    gv  = pick_any;
    if (state_q == ST_LOCK) begin
      gid = owner_q;
      gv  = 1'b1;
    end
  end
`else
  assign gid = pick_idx;
  assign gv  = pick_any;
`endif

  assign accept = rst_n & gv & req_valid[gid] & ~fifo_full;

  // output muxing; everything forced quiet while in reset
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gid] = 1'b1;
    fifo_wr_en  = accept;
    grant_valid = rst_n & gv;
    grant_id    = rst_n ? gid : '0;
    fifo_data   = '0;
    if (rst_n && gv) fifo_data = `FIFO_ARB_SLICE(req_data, gid, WIDTH);
  end

`ifdef FIFO_ARB_BURST_EN
  // burst FSM: lock on first beat, release on count or owner drop
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_ARB: begin
        if (accept) begin
          owner_d = gid;
          cnt_d   = CW'(1);
          if (MAX_BURST > 1) state_d = ST_LOCK;
          else rr_ptr_d = nxt(gid);
        end
      end
      ST_LOCK: begin
        if (!fifo_full) begin
          if (req_valid[owner_q]) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(MAX_BURST)) begin
              state_d  = ST_ARB;
              rr_ptr_d = nxt(owner_q);
              cnt_d    = '0;
            end
          end else begin
            state_d  = ST_ARB;
            rr_ptr_d = nxt(owner_q);
            cnt_d    = '0;
          end
        end
      end
    endcase
  end

  // state, owner, beat count and pointer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ARB;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // every accepted beat moves the pointer past the winner
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = nxt(gid);
  end

  // round-robin pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter against a queue-based model.
// Burst checks follow FIFO_ARB_BURST_EN when it is defined.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data;
  logic           grant_valid;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data   (fifo_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  typedef struct {
    int         cyc;
    bit         rst;
    bit         gv;
    int         gid;
    bit [N-1:0] rdy;
    bit [W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  int         m_ptr   = 0;
  bit         m_lock  = 0;
  int         m_owner = 0;
  int         m_cnt   = 0;
  bit [N-1:0] vld     = '0;
  bit [W-1:0] d[N];
  bit         held[N];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp, input int c);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [N-1:0] want, input bit f);
    exp_t e;
    int   g;
    bit   any;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!held[i]) begin
        vld[i] = want[i];
        d[i]   = $urandom;
      end
      req_data[i*W +: W] = d[i];
    end
    req_valid = vld;
    rst_n     = r;
    fifo_full = f;
    e.cyc = cyc;
    e.rst = r;
    if (!r) begin
      e.gv = 0; e.gid = 0; e.rdy = '0; e.data = '0;
      m_ptr = 0; m_lock = 0; m_cnt = 0;
    end else begin
      any = 0;
      g   = 0;
      if (m_lock) begin
        any = 1;
        g   = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (!any && vld[(m_ptr+k)%N]) begin
            any = 1;
            g   = (m_ptr + k) % N;
          end
      end
      e.gv   = any;
      e.gid  = g;
      e.rdy  = (any && vld[g] && !f) ? N'(1 << g) : '0;
      e.data = any ? d[g] : '0;
`ifdef FIFO_ARB_BURST_EN
      if (m_lock) begin
        if (!f) begin
          if (vld[g]) begin
            m_cnt++;
            if (m_cnt == MB) begin
              m_lock = 0;
              m_ptr  = (g + 1) % N;
            end
          end else begin
            m_lock = 0;
            m_ptr  = (g + 1) % N;
          end
        end
      end else if (e.rdy != 0) begin
        m_owner = g;
        m_cnt   = 1;
        if (MB > 1) m_lock = 1;
        else m_ptr = (g + 1) % N;
      end
`else
      if (e.rdy != 0) m_ptr = (g + 1) % N;
`endif
    end
    for (int i = 0; i < N; i++) held[i] = vld[i] && !e.rdy[i];
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("grant_valid", grant_valid, e.gv, e.cyc);
      if (e.gv || !e.rst)
        check("grant_id", grant_id, e.gid, e.cyc);
      check("req_ready", req_ready, e.rdy, e.cyc);
      check("fifo_wr_en", fifo_wr_en, |e.rdy, e.cyc);
      check("fifo_data", fifo_data, e.data, e.cyc);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      held[i] = 0;
      d[i]    = '0;
    end
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) drive(0, 4'hF, 0);
    repeat (8) drive(1, 4'hF, 0);
    repeat (2*N) drive(1, 4'h0, 0);
    repeat (3) drive(1, 4'b0100, 1);
    drive(1, 4'b0000, 0);
    repeat (3) drive(1, 4'b0101, 0);
    repeat (2*N) drive(1, 4'h0, 0);
    repeat (6) drive(1, 4'b1010, 0);
    repeat (2) drive(1, 4'b1000, 0);
    drive(1, 4'b0000, 0);
    repeat (2*N) drive(1, 4'h0, 0);
    repeat (4) drive(1, 4'b0011, 0);
    drive(0, 4'b0011, 0);
    repeat (4) drive(1, 4'b0011, 0);
    repeat (3000)
      drive($urandom_range(0, 39) != 0, N'($urandom),
            $urandom_range(0, 3) == 0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
